gbc_capture_sync: RTL and testbench
===================================

Name: gbc_capture_sync

Overview:
- Upstream stage of the frame buffer: samples the raw GBC LCD bus (DCLK, CLS, SPS, 3-bit pixel data) in the pixel clock domain.
- Produces single-cycle VRAM write strobes with a linear 160x144 address and 8-bit RGB332 colour.
- Lets the VRAM write port run on i_clkPixel instead of the raw GBC DCLK.
- Sits between the IO_P6 pins and the sram write port; replaces the asynchronous capture path.

Parameters:
H_PIXELS, 160, accepted pixels per line
V_PIXELS, 144, accepted lines per frame
ADDR_WIDTH, 15, VRAM address width
SYNC_STAGES, 2, synchroniser flops per input (minimum 2)

Ports:
i_clkPixel  input  1  pixel clock (74.25 MHz); all logic on its rising edge
i_reset  input  1  asynchronous active-high reset
i_gbcDCLK  input  1  raw GBC dot clock; pixel valid on its falling edge
i_gbcCLS  input  1  raw GBC line pulse; rising edge = line start
i_gbcSPS  input  1  raw GBC frame pulse; rising edge = frame start
i_gbcPixelData  input  3  raw GBC pixel shade
o_vramWriteAddr  output  ADDR_WIDTH  linear address, y*H_PIXELS+x
o_vramWriteData  output  8  RGB332 colour
o_vramWriteEnable  output  1  one-cycle write strobe per accepted pixel
o_frameStart  output  1  one-cycle pulse on each accepted SPS rising edge
o_locked  output  1  high while in S_FRAME

Behaviour:
- Reset: async on i_reset high.
  - All outputs 0; x=0, y=0, rowBase=0.
  - State S_WAIT_FRAME; all synchroniser flops 0.
- Synchronisers:
  - SYNC_STAGES flops on each of DCLK, CLS, SPS and data[2:0].
  - One extra history flop per control line for edge detection.
  - Edges: dclkFall = prev & ~cur; clsRise and spsRise = ~prev & cur.
- Data capture: data sampled from its synchronised copy in the same cycle dclkFall is detected; DCLK and data share equal sync depth.
- Colour map, with d = data: R = d[2:0], G = d[2:0], B = d[2:1]. o_vramWriteData = {R,G,B}.
- State S_WAIT_FRAME:
  - Ignores DCLK and CLS.
  - spsRise -> S_FRAME; y=0, rowBase=0, x=0, firstLine=1, o_frameStart=1 for one cycle.
- State S_FRAME, event priority within one cycle: spsRise > clsRise > dclkFall.
  - spsRise: re-sync exactly as above; any pending line is abandoned.
  - clsRise with firstLine=1: firstLine<=0, x<=0, y and rowBase unchanged.
  - clsRise with firstLine=0: x<=0, y<=y+1, rowBase<=rowBase+H_PIXELS. If y was V_PIXELS-1, y saturates at V_PIXELS and state stays S_FRAME.
  - dclkFall with x<H_PIXELS and y<V_PIXELS: o_vramWriteEnable=1 for exactly one cycle, o_vramWriteAddr=rowBase+x, data per colour map, then x<=x+1.
  - dclkFall with x==H_PIXELS or y==V_PIXELS: pixel dropped, no strobe, x holds.
  - clsRise and dclkFall in the same cycle: line start applied first; the pixel is written at x=0 of the new line.
- Address arithmetic: rowBase + x only, no multiplier. Max address 23039; never exceeds H_PIXELS*V_PIXELS-1.
- Latency: o_vramWriteEnable rises SYNC_STAGES+2 i_clkPixel cycles after the raw DCLK falling edge. That is 4 cycles at default, fixed, ±1 cycle for input phase.
- Strobe rate: at most one strobe per DCLK period. Address and data are held stable between strobes.
- Reset mid-frame: immediate return to S_WAIT_FRAME; no strobes until the next spsRise.
- o_locked = (state == S_FRAME).

Optional Feature:
GBC_LINE_CHECK_EN:
- Defined:
  - Adds output o_lineError (1 bit, reset 0).
  - On each clsRise in S_FRAME with firstLine=0, if the previous line's accepted-plus-dropped pixel count != H_PIXELS, o_lineError goes high and stays high (sticky).
  - Cleared only by i_reset.
  - The extra pixel counter saturates at 255.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then 20 DCLK pulses with no SPS -> zero write strobes, o_locked=0.
- SPS, CLS, then 160 DCLK falls with data=3'b101 -> 160 strobes at addr 0..159, data 8'hB6, o_frameStart one pulse, o_locked=1.
- Full frame of 144 lines x 160 pixels, then a second SPS -> last strobe addr 23039; next frame restarts at addr 0 with one o_frameStart pulse.
- Line of 165 DCLK falls -> only 160 strobes, next line starts at addr rowBase+160. With GBC_LINE_CHECK_EN, o_lineError=1 after the next CLS.
- CLS rise and DCLK fall in the same cycle on line 2 -> strobe at addr 160; strobe 4 cycles after the raw DCLK edge.
- Assert i_reset mid-line at x=80 -> outputs 0 immediately; no strobes until the next SPS, then addr restarts at 0.

Source files
------------

// File: rtl/gbc_capture_sync.sv
// gbc_capture_sync
//
// Captures the raw Game Boy Color LCD bus in the pixel clock domain. The
// controls and the pixel shade are resynchronised, and edges are detected
// on the synchronised copies. Accepted pixels become single-cycle VRAM
// write strobes. Each strobe carries a linear 160x144 address and an
// RGB332 colour.
//
// Ports
//   i_clkPixel         pixel clock; every flop runs on its rising edge
//   i_reset            asynchronous active-high reset
//   i_gbcDCLK          raw dot clock; pixel is valid on its falling edge
//   i_gbcCLS           raw line pulse; a rising edge starts a line
//   i_gbcSPS           raw frame pulse; a rising edge starts a frame
//   i_gbcPixelData     raw 3-bit pixel shade
//   o_vramWriteAddr    linear write address, y*H_PIXELS + x
//   o_vramWriteData    RGB332 colour
//   o_vramWriteEnable  one-cycle strobe per accepted pixel
//   o_frameStart       one-cycle pulse per accepted frame start
//   o_locked           high while the capture is tracking a frame
//   o_lineError        (GBC_LINE_CHECK_EN only) sticky flag. It is set when
//                      a completed line did not carry exactly H_PIXELS dots.
//
// Optional feature macro: GBC_LINE_CHECK_EN
//
// Latency: a raw DCLK fall produces a strobe SYNC_STAGES+2 clocks later.
// The breakdown is SYNC_STAGES synchroniser flops, one registered-event
// stage and the output register. SYNC_STAGES must be at least 2.

module gbc_capture_sync #(
  parameter int H_PIXELS    = 160,
  parameter int V_PIXELS    = 144,
  parameter int ADDR_WIDTH  = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clkPixel,
  input  logic                  i_reset,
  input  logic                  i_gbcDCLK,
  input  logic                  i_gbcCLS,
  input  logic                  i_gbcSPS,
  input  logic [2:0]            i_gbcPixelData,
  output logic [ADDR_WIDTH-1:0] o_vramWriteAddr,
  output logic [7:0]            o_vramWriteData,
  output logic                  o_vramWriteEnable,
  output logic                  o_frameStart,
  output logic                  o_locked
`ifdef GBC_LINE_CHECK_EN
  ,
  output logic                  o_lineError
`endif
);

  // x must be able to hold H_PIXELS, because it parks there once a line is full.
  // y must be able to hold V_PIXELS, because it saturates there after the last line.
  localparam int X_W = $clog2(H_PIXELS + 1);
  localparam int Y_W = $clog2(V_PIXELS + 1);

  typedef enum logic {
    S_WAIT_FRAME,
    S_FRAME
  } state_t;

  function automatic logic [7:0] rgb332(input logic [2:0] d);
    return {d, d, d[2:1]};
  endfunction

  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] cls_sync;
  logic [SYNC_STAGES-1:0] sps_sync;
  logic [2:0]             data_sync [SYNC_STAGES];
  logic                   dclk_hist;
  logic                   cls_hist;
  logic                   sps_hist;

  logic                   dclk_fall;
  logic                   cls_rise;
  logic                   sps_rise;

  logic                   dclk_fall_p0;
  logic                   cls_rise_p0;
  logic                   sps_rise_p0;
  logic [2:0]             data_p0;

  state_t                 state_q;
  state_t                 state_d;
  logic [X_W-1:0]         x_q;
  logic [X_W-1:0]         x_d;
  logic [Y_W-1:0]         y_q;
  logic [Y_W-1:0]         y_d;
  logic [ADDR_WIDTH-1:0]  row_base_q;
  logic [ADDR_WIDTH-1:0]  row_base_d;
  logic                   first_line_q;
  logic                   first_line_d;
  logic                   we_d;
  logic                   fs_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [7:0]             data_d;
  logic [X_W-1:0]         x_eff;
  logic [Y_W-1:0]         y_eff;
  logic [ADDR_WIDTH-1:0]  base_eff;

  // ---- synchroniser stages: raw pins -> sync chains + edge history ----
  always_ff @(posedge i_clkPixel or posedge i_reset) begin
    if (i_reset) begin
      dclk_sync <= '0;
      cls_sync  <= '0;
      sps_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      dclk_hist <= 1'b0;
      cls_hist  <= 1'b0;
      sps_hist  <= 1'b0;
    end else begin
      dclk_sync    <= {dclk_sync[SYNC_STAGES-2:0], i_gbcDCLK};
      cls_sync     <= {cls_sync[SYNC_STAGES-2:0],  i_gbcCLS};
      sps_sync     <= {sps_sync[SYNC_STAGES-2:0],  i_gbcSPS};
      data_sync[0] <= i_gbcPixelData;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      dclk_hist    <= dclk_sync[SYNC_STAGES-1];
      cls_hist     <= cls_sync[SYNC_STAGES-1];
      sps_hist     <= sps_sync[SYNC_STAGES-1];
    end
  end

  assign dclk_fall = dclk_hist & ~dclk_sync[SYNC_STAGES-1];
  assign cls_rise  = ~cls_hist & cls_sync[SYNC_STAGES-1];
  assign sps_rise  = ~sps_hist & sps_sync[SYNC_STAGES-1];

  // ---- p0: registered events, data taken alongside the DCLK fall ----
  always_ff @(posedge i_clkPixel or posedge i_reset) begin
    if (i_reset) begin
      dclk_fall_p0 <= 1'b0;
      cls_rise_p0  <= 1'b0;
      sps_rise_p0  <= 1'b0;
      data_p0      <= '0;
    end else begin
      dclk_fall_p0 <= dclk_fall;
      cls_rise_p0  <= cls_rise;
      sps_rise_p0  <= sps_rise;
      data_p0      <= data_sync[SYNC_STAGES-1];
    end
  end

  // ---- p1: frame/line tracking and write strobe generation ----
  always_ff @(posedge i_clkPixel or posedge i_reset) begin
    if (i_reset) begin
      state_q           <= S_WAIT_FRAME;
      x_q               <= '0;
      y_q               <= '0;
      row_base_q        <= '0;
      first_line_q      <= 1'b0;
      o_vramWriteEnable <= 1'b0;
      o_frameStart      <= 1'b0;
      o_vramWriteAddr   <= '0;
      o_vramWriteData   <= '0;
    end else begin
      state_q           <= state_d;
      x_q               <= x_d;
      y_q               <= y_d;
      row_base_q        <= row_base_d;
      first_line_q      <= first_line_d;
      o_vramWriteEnable <= we_d;
      o_frameStart      <= fs_d;
      o_vramWriteAddr   <= addr_d;
      o_vramWriteData   <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    first_line_d = first_line_q;
    we_d         = 1'b0;
    fs_d         = 1'b0;
    addr_d       = o_vramWriteAddr;
    data_d       = o_vramWriteData;
    x_eff        = x_q;
    y_eff        = y_q;
    base_eff     = row_base_q;

    case (state_q)
      S_WAIT_FRAME: begin
        if (sps_rise_p0) begin
          state_d      = S_FRAME;
          x_d          = '0;
          y_d          = '0;
          row_base_d   = '0;
          first_line_d = 1'b1;
          fs_d         = 1'b1;
        end
      end
      S_FRAME: begin
        if (sps_rise_p0) begin
          x_d          = '0;
          y_d          = '0;
          row_base_d   = '0;
          first_line_d = 1'b1;
          fs_d         = 1'b1;
        end else begin
          // A line start is applied before a pixel arriving in the same
          // cycle, so that pixel lands at x=0 of the new line.
          if (cls_rise_p0) begin
            x_eff        = '0;
            first_line_d = 1'b0;
            if (!first_line_q && (y_q < Y_W'(V_PIXELS))) begin
              y_eff    = y_q + Y_W'(1);
              base_eff = row_base_q + ADDR_WIDTH'(H_PIXELS);
            end
          end
          if (dclk_fall_p0 && (x_eff < X_W'(H_PIXELS)) && (y_eff < Y_W'(V_PIXELS))) begin
            we_d   = 1'b1;
            addr_d = base_eff + ADDR_WIDTH'(x_eff);
            data_d = rgb332(data_p0);
            x_eff  = x_eff + X_W'(1);
          end
          x_d        = x_eff;
          y_d        = y_eff;
          row_base_d = base_eff;
        end
      end
      default: state_d = S_WAIT_FRAME;
    endcase
  end

  assign o_locked = (state_q == S_FRAME);

`ifdef GBC_LINE_CHECK_EN
  // Counts every DCLK fall (accepted or dropped) since the last line start.
  logic [7:0] line_cnt_q;
  logic [7:0] line_cnt_d;
  logic       line_err_d;

  always_comb begin
    line_cnt_d = line_cnt_q;
    line_err_d = o_lineError;
    if (sps_rise_p0) begin
      line_cnt_d = '0;
    end else if (state_q == S_FRAME) begin
      if (cls_rise_p0) begin
        if (!first_line_q && (line_cnt_q != 8'(H_PIXELS))) line_err_d = 1'b1;
        line_cnt_d = '0;
      end
      if (dclk_fall_p0 && (line_cnt_d != 8'hFF)) line_cnt_d = line_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge i_clkPixel or posedge i_reset) begin
    if (i_reset) begin
      line_cnt_q  <= '0;
      o_lineError <= 1'b0;
    end else begin
      line_cnt_q  <= line_cnt_d;
      o_lineError <= line_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_gbc_capture_sync.sv
`timescale 1ns/1ps
module tb_gbc_capture_sync;
  localparam int H  = 160;
  localparam int V  = 144;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          dclk;
  logic          cls;
  logic          sps;
  logic [2:0]    data;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          we;
  logic          fs;
  logic          locked;
`ifdef GBC_LINE_CHECK_EN
  logic          line_err;
`endif

  always #5 clk = ~clk;

  gbc_capture_sync dut (
    .i_clkPixel        (clk),
    .i_reset           (rst),
    .i_gbcDCLK         (dclk),
    .i_gbcCLS          (cls),
    .i_gbcSPS          (sps),
    .i_gbcPixelData    (data),
    .o_vramWriteAddr   (addr),
    .o_vramWriteData   (wdata),
    .o_vramWriteEnable (we),
    .o_frameStart      (fs),
    .o_locked          (locked)
`ifdef GBC_LINE_CHECK_EN
    ,
    .o_lineError       (line_err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct {
    int         a;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  bit   m_locked, m_first, m_err;
  int   m_x, m_y, m_cnt;

  function automatic void model_reset();
    m_locked = 0; m_first = 0; m_err = 0; m_x = 0; m_y = 0; m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_sps();
    m_locked = 1; m_first = 1; m_x = 0; m_y = 0; m_cnt = 0;
  endfunction

  function automatic void model_cls();
    if (!m_locked) return;
    if (m_first) m_first = 0;
    else begin
      if (m_cnt != H) m_err = 1;
      if (m_y < V) m_y = m_y + 1;
    end
    m_x = 0; m_cnt = 0;
  endfunction

  function automatic void model_pix(input logic [2:0] d);
    exp_t e;
    if (!m_locked) return;
    if (m_cnt < 255) m_cnt = m_cnt + 1;
    if (m_x < H && m_y < V) begin
      e.a = m_y * H + m_x;
      e.d = {d, d, d[2:1]};
      if (mon_en) exp_q.push_back(e);
      m_x = m_x + 1;
    end
  endfunction

  // ---------------- output monitor ----------------
  int         strobe_cnt = 0;
  int         fs_cnt     = 0;
  int         last_addr  = -1;
  logic [7:0] last_data  = '0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (fs === 1'b1) fs_cnt++;
    if (we === 1'b1) begin
      strobe_cnt++;
      last_addr = int'(addr);
      last_data = wdata;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got addr %0d data 0x%0h, expected no strobe", addr, wdata);
        end else begin
          e = exp_q.pop_front();
          if (int'(addr) != e.a || wdata !== e.d) begin
            failures++;
            $display("FAIL strobe: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                     addr, wdata, e.a, e.d);
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks (inputs change on negedge) ----------------
  task automatic pixel(input logic [2:0] d);
    @(negedge clk); data = d; dclk = 1'b1;
    @(negedge clk); dclk = 1'b0; model_pix(d);
  endtask

  task automatic cls_pulse();
    @(negedge clk); cls = 1'b1; model_cls();
    @(negedge clk); cls = 1'b0;
  endtask

  task automatic sps_pulse();
    @(negedge clk); sps = 1'b1; model_sps();
    @(negedge clk); sps = 1'b0;
  endtask

  task automatic cls_pix(input logic [2:0] d);
    @(negedge clk); data = d; dclk = 1'b1;
    @(negedge clk); dclk = 1'b0; cls = 1'b1; model_cls(); model_pix(d);
    @(negedge clk); cls = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Counts posedges from the current point until a strobe is seen (bounded).
  task automatic wait_strobe(output int cyc, output bit got);
    cyc = 0; got = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (we === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] d;
    logic [7:0] exp_data;
    int         exp_addr;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int s0, f0, cyc, n;
    bit got;

    tbl[0] = '{3'b000, 8'h00, 0};
    tbl[1] = '{3'b001, 8'h24, 1};
    tbl[2] = '{3'b010, 8'h49, 2};
    tbl[3] = '{3'b011, 8'h6D, 3};
    tbl[4] = '{3'b100, 8'h92, 4};
    tbl[5] = '{3'b101, 8'hB6, 5};
    tbl[6] = '{3'b110, 8'hDB, 6};
    tbl[7] = '{3'b111, 8'hFF, 7};

    rst = 1'b1; dclk = 1'b0; cls = 1'b0; sps = 1'b0; data = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_we", we, 0);
    chk("reset_fs", fs, 0);
    chk("reset_locked", locked, 0);
    chk("reset_addr", addr, 0);
    chk("reset_data", wdata, 0);
`ifdef GBC_LINE_CHECK_EN
    chk("reset_line_err", line_err, 0);
`endif
    rst = 1'b0;

    // DCLK activity without a frame start is ignored.
    mon_en = 1'b1;
    s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      pixel(3'($urandom_range(0, 7)));
      if (i == 10) cls_pulse();
    end
    drain();
    chk("nosps_strobes", strobe_cnt - s0, 0);
    chk("nosps_locked", locked, 0);
    chk("nosps_fs", fs_cnt, 0);

    // Colour map table with fixed latency from the raw DCLK fall.
    mon_en = 1'b0;
    f0 = fs_cnt;
    sps_pulse();
    repeat (6) @(negedge clk);
    chk("tbl_fs_pulses", fs_cnt - f0, 1);
    chk("tbl_locked", locked, 1);
    cls_pulse();
    for (int i = 0; i < 8; i++) begin
      pixel(tbl[i].d);
      wait_strobe(cyc, got);
      chk("tbl_strobe_seen", got, 1);
      chk("tbl_addr", addr, tbl[i].exp_addr);
      chk("tbl_data", wdata, tbl[i].exp_data);
      chk("tbl_latency", cyc, 4);
    end

    // One full line of shade 101.
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    f0 = fs_cnt; s0 = strobe_cnt;
    sps_pulse();
    cls_pulse();
    for (int i = 0; i < H; i++) pixel(3'b101);
    drain();
    chk("line_strobes", strobe_cnt - s0, H);
    chk("line_last_addr", last_addr, H - 1);
    chk("line_last_data", last_data, 8'hB6);
    chk("line_fs_pulses", fs_cnt - f0, 1);
    chk("line_locked", locked, 1);

    // Full frame plus saturation after the last line, then a new frame.
    s0 = strobe_cnt;
    sps_pulse();
    for (int y = 0; y < V; y++) begin
      cls_pulse();
      for (int x = 0; x < H; x++) pixel(3'($urandom_range(0, 7)));
    end
    drain();
    chk("frame_strobes", strobe_cnt - s0, H * V);
    chk("frame_last_addr", last_addr, H * V - 1);
    cls_pulse();
    for (int i = 0; i < 5; i++) pixel(3'b111);
    drain();
    chk("saturated_no_strobes", strobe_cnt - s0, H * V);
`ifdef GBC_LINE_CHECK_EN
    chk("frame_line_err", line_err, m_err);
`endif
    f0 = fs_cnt;
    sps_pulse();
    cls_pulse();
    pixel(3'b010);
    drain();
    chk("newframe_addr", last_addr, 0);
    chk("newframe_fs_pulses", fs_cnt - f0, 1);

    // Overlong line: 165 dots, only 160 accepted.
    sps_pulse();
    cls_pulse();
    s0 = strobe_cnt;
    for (int i = 0; i < 165; i++) pixel(3'($urandom_range(0, 7)));
    drain();
    chk("long_strobes", strobe_cnt - s0, H);
    cls_pulse();
    pixel(3'b001);
    drain();
    chk("long_next_addr", last_addr, H);
`ifdef GBC_LINE_CHECK_EN
    chk("long_line_err", line_err, 1);
`endif

    // CLS rise and DCLK fall in the same cycle at the start of line 2.
    sps_pulse();
    cls_pulse();
    for (int i = 0; i < H; i++) pixel(3'($urandom_range(0, 7)));
    drain();
    mon_en = 1'b0;
    @(negedge clk); data = 3'b011; dclk = 1'b1;
    @(negedge clk); dclk = 1'b0; cls = 1'b1; model_cls(); model_pix(3'b011);
    wait_strobe(cyc, got);
    chk("simul_strobe_seen", got, 1);
    chk("simul_addr", addr, H);
    chk("simul_data", wdata, 8'h6D);
    chk("simul_latency", cyc, 4);
    @(negedge clk); cls = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Randomised lines of varying length, random CLS/DCLK coincidence,
    // and one frame restart in the middle of a line.
    sps_pulse();
    for (int ln = 0; ln < 40; ln++) begin
      n = $urandom_range(150, 170);
      if ($urandom_range(0, 3) == 0) begin
        cls_pix(3'($urandom_range(0, 7)));
        n = n - 1;
      end else begin
        cls_pulse();
      end
      for (int i = 0; i < n; i++) begin
        if (ln == 20 && i == 70) sps_pulse();
        pixel(3'($urandom_range(0, 7)));
      end
    end
    drain();
`ifdef GBC_LINE_CHECK_EN
    chk("random_line_err", line_err, m_err);
`endif

    // Reset in the middle of a line.
    sps_pulse();
    cls_pulse();
    for (int i = 0; i < 80; i++) pixel(3'($urandom_range(0, 7)));
    drain();
    @(negedge clk); rst = 1'b1; model_reset();
    #1;
    chk("midreset_we", we, 0);
    chk("midreset_addr", addr, 0);
    chk("midreset_data", wdata, 0);
    chk("midreset_locked", locked, 0);
    chk("midreset_fs", fs, 0);
`ifdef GBC_LINE_CHECK_EN
    chk("midreset_line_err", line_err, 0);
`endif
    @(negedge clk); rst = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) pixel(3'b110);
    cls_pulse();
    pixel(3'b110);
    drain();
    chk("postreset_no_strobes", strobe_cnt - s0, 0);
    chk("postreset_locked", locked, 0);
    sps_pulse();
    cls_pulse();
    pixel(3'b111);
    drain();
    chk("postreset_addr", last_addr, 0);
    chk("postreset_data", last_data, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
